add_arbiter: RTL



---
 rtl/add_arb_pkg.sv | 25 ++
 rtl/add_arbiter_rr_pick.sv | 58 +++++
 rtl/add_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/add_arb_pkg.sv
// ============================================================================
//  Module      : add_arb_pkg
//  Description : Shared types and default constants for the add_arbiter
//                slice: FSM state encoding and default build parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_arb_pkg;

    // Default build parameters
    localparam int c_N_REQ   = 4;
    localparam int c_W       = 8;
    localparam int c_ADD_LAT = 1;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : add_arb_pkg

`default_nettype wire

// File: rtl/add_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches req starting at
//                ptr and moving upward with wrap; the first set bit wins.
//  Ports       : req     - request vector
//                ptr     - requester index with highest priority
//                any_req - at least one request bit set
//                winner  - index of the selected requester
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import add_arb_pkg::*;
#(
    parameter int N_REQ = c_N_REQ,
    parameter int ID_W  = $clog2(c_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any_req,
    output logic [ID_W-1:0]  winner
);

    // One extra bit so j + N_REQ - ptr never overflows
    localparam int c_OFF_W = ID_W + 1;

    logic [c_OFF_W-1:0] w_off;
    logic [c_OFF_W-1:0] w_best;
    logic [c_OFF_W-1:0] w_j;
    logic [c_OFF_W-1:0] w_p;

    // Each requester's distance from ptr (modulo N_REQ); the smallest
    // distance among active requesters is the round-robin winner.
    always_comb begin
        any_req = |req;
        winner  = '0;
        w_best  = '1;
        w_off   = '0;
        w_j     = '0;
        w_p     = {1'b0, ptr};
        for (int j = 0; j < N_REQ; j++) begin
            w_j = c_OFF_W'(j);
            if (w_j >= w_p) begin
                w_off = w_j - w_p;
            end else begin
                w_off = w_j + c_OFF_W'(N_REQ) - w_p;
            end
            if (req[j] && (w_off < w_best)) begin
                w_best = w_off;
                winner = ID_W'(j);
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/add_arbiter.sv
// ============================================================================
//  Module      : add_arbiter
//  Description : Shares one external registered adder between N_REQ
//                requesters. A round-robin winner's operands are latched onto
//                add_a/add_b, the adder latency is waited out, and the sum is
//                returned with a one-cycle ack/rsp_valid pulse.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                req, op_a, op_b    - per-requester request and packed operands
//                ack                - one-hot, one-cycle pulse to served requester
//                rsp_valid/id/data  - response, valid with ack
//                add_a, add_b       - operands to the external adder
//                add_c              - external adder result
//                busy               - high whenever not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ   = c_N_REQ,
    parameter int W       = c_W,
    parameter int ADD_LAT = c_ADD_LAT,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op_a,
    input  logic [N_REQ*W-1:0] op_b,
    output logic [N_REQ-1:0]   ack,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_data,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    input  logic [W-1:0]       add_c,
    output logic               busy
);

    localparam int c_CNT_W = $clog2(ADD_LAT + 1);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic [c_CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0]   r_ack;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [W-1:0]       r_rsp_data;
    logic [W-1:0]       r_add_a;
    logic [W-1:0]       r_add_b;
    logic               r_busy;

    logic               w_any;
    logic [ID_W-1:0]    w_win;
    logic [W-1:0]       w_sel_a;
    logic [W-1:0]       w_sel_b;
    logic [ID_W-1:0]    w_ptr_next;

    rr_pick #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (r_ptr),
        .any_req (w_any),
        .winner  (w_win)
    );

    // Operand slice mux for the current winner
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_win == ID_W'(j)) begin
                w_sel_a = op_a[j*W +: W];
                w_sel_b = op_b[j*W +: W];
            end
        end
    end

    // Priority moves to the requester just after the one served
    assign w_ptr_next = (r_gnt_id == ID_W'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_id    <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_busy      <= 1'b0;
        end else begin
            // Response pulses last exactly one cycle
            r_ack       <= '0;
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_add_a  <= w_sel_a;
                        r_add_b  <= w_sel_b;
                        r_gnt_id <= w_win;
                        r_cnt    <= c_CNT_W'(ADD_LAT);
                        r_state  <= BUSY;
                        r_busy   <= 1'b1;
                    end
                end
                BUSY: begin
                    // cnt reaching zero means add_c now reflects add_a/add_b
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_data  <= add_c;
                        r_rsp_id    <= r_gnt_id;
                        r_rsp_valid <= 1'b1;
                        r_ack       <= N_REQ'(1) << r_gnt_id;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign busy      = r_busy;

endmodule : add_arbiter

`default_nettype wire
